bin_to_bcd_seq: RTL and testbench

- Sequential binary-to-BCD converter using shift-add-3 (double dabble), one bit per clock.
- Sits directly downstream of divider_nr: `start` is driven by the divider's `done`, and `bin_in` by its `quotient` or `remainder`.
- Produces packed decimal digits plus a leading-zero blanking mask for the seven-segment display driver.

---
 rtl/bin_to_bcd_seq.sv | 121 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one input bit per clock.
// Produces packed BCD digits and a leading-zero blanking mask for a display driver.
module bin_to_bcd_seq #(
    parameter int BITS   = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BITS-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [1:0]            o_dbg_state
);

    // Handshake: start is a one-cycle request honoured only in IDLE or DONE;
    // done is a one-cycle pulse and bcd_out/digit_valid hold until the next done.

    function automatic logic [127:0] pow10(input int n);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 128'd10;
        end
        return p;
    endfunction

    localparam logic [127:0] MAX_BIN = (128'd1 << BITS) - 128'd1;
    localparam int CW = $clog2(BITS + 1);

    generate
        if (pow10(DIGITS) <= MAX_BIN) begin : g_capacity_check
            $error("bin_to_bcd_seq: DIGITS too small to hold 2**BITS-1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    logic [BITS-1:0]       r_shift;
    logic [4*DIGITS-1:0]   r_bcd;
    logic [CW-1:0]         r_cnt;
    logic [4*DIGITS-1:0]   w_adj;
    logic [DIGITS-1:0]     w_dv;
    logic                  w_any;

    assign o_dbg_state = r_state;

    always_comb begin
        w_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // A digit is shown if it or any more-significant digit is nonzero; ones always shown.
    always_comb begin
        w_dv  = '0;
        w_any = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_any   = w_any | (r_bcd[4*k +: 4] != 4'd0);
            w_dv[k] = w_any;
        end
        w_dv[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd_out     <= '0;
            digit_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_shift <= bin_in;
                        r_bcd   <= '0;
                        r_cnt   <= CW'(BITS);
                        busy    <= 1'b1;
                        r_state <= S_SHIFT;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt == '0) begin
                        bcd_out     <= r_bcd;
                        digit_valid <= w_dv;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_bcd   <= {w_adj[4*DIGITS-2:0], r_shift[BITS-1]};
                        r_shift <= {r_shift[BITS-2:0], 1'b0};
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: driver pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_bin_to_bcd_seq;

    localparam int BITS   = 16;
    localparam int DIGITS = 5;
    localparam int LAT    = BITS + 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [BITS-1:0]     bin_in;
    logic                busy;
    logic                done;
    logic [4*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]   digit_valid;
    logic [1:0]          dbg_state;

    bin_to_bcd_seq #(.BITS(BITS), .DIGITS(DIGITS)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bin_in      (bin_in),
        .busy        (busy),
        .done        (done),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .o_dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [4*DIGITS-1:0] exp_q[$];
    logic [DIGITS-1:0]   exp_dv_q[$];
    int                  exp_cyc_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    endtask

    // reference model: decimal digits by plain division
    function automatic logic [4*DIGITS-1:0] model_bcd(input int unsigned v);
        logic [4*DIGITS-1:0] r;
        int unsigned p;
        r = '0;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [DIGITS-1:0] model_dv(input int unsigned v);
        logic [DIGITS-1:0] m;
        int unsigned p;
        p = 1;
        for (int k = 0; k < DIGITS; k++) begin
            m[k] = ((v / p) != 0);
            p = p * 10;
        end
        m[0] = 1'b1;
        return m;
    endfunction

    // monitor
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got done=1 expected no pending conversion (cycle %0d)", cyc);
            end else begin
                chk("bcd_out", 64'(bcd_out), 64'(exp_q.pop_front()));
                chk("digit_valid", 64'(digit_valid), 64'(exp_dv_q.pop_front()));
                chk("latency", 64'(cyc), 64'(exp_cyc_q.pop_front()));
                chk("busy_in_done", 64'(busy), 64'd0);
            end
        end
    end

    // driver tasks
    task automatic do_start(input int unsigned v, input bit now);
        if (!now) @(negedge clk);
        start  = 1'b1;
        bin_in = BITS'(v);
        exp_q.push_back(model_bcd(v));
        exp_dv_q.push_back(model_dv(v));
        exp_cyc_q.push_back(cyc + 1 + LAT);
        @(negedge clk);
        start  = 1'b0;
        bin_in = BITS'($urandom_range(0, 65535));
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 4 * LAT) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", 4 * LAT);
        end
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_bcd", 64'(bcd_out), 64'd0);
        chk("reset_dv", 64'(digit_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // directed values, including capacity and edge cases
        do_start(3, 0);     wait_done();
        do_start(65535, 0); wait_done();
        do_start(0, 0);     wait_done();
        do_start(1000, 0);  wait_done();

        // start while busy is ignored
        do_start(12345, 0);
        repeat (3) @(negedge clk);
        start = 1'b1; bin_in = 16'd99;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        chk("hold_after_done", 64'(bcd_out), 64'h12345);

        // back-to-back: start during the done cycle
        do_start(42, 1);
        wait_done();

        // reset mid-conversion aborts it; start coincident with reset ignored
        @(negedge clk);
        do_start(54321, 0);
        repeat (6) @(negedge clk);
        reset = 1'b1; start = 1'b1; bin_in = 16'd5;
        exp_q.delete(); exp_dv_q.delete(); exp_cyc_q.delete();
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_bcd", 64'(bcd_out), 64'd0);
        chk("abort_dv", 64'(digit_valid), 64'd0);
        repeat (2 * LAT) @(negedge clk);
        chk("abort_no_done_busy", 64'(busy), 64'd0);
        do_start(7, 0); wait_done();

        // random values, some issued back-to-back in the done cycle
        for (int i = 0; i < 100; i++) begin
            do_start($urandom_range(0, 65535), ($urandom_range(0, 1) == 1) && done);
            if ($urandom_range(0, 3) == 0) begin
                repeat (4) @(negedge clk);
                start = 1'b1; bin_in = BITS'($urandom);
                @(negedge clk);
                start = 1'b0;
            end
            wait_done();
        end

        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
